// File: rtl/riscv_types.sv
// Shared types and constants for the FP multiply round/pack stage.
package riscv_types;

  localparam int unsigned RD_W = 5;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            reg_write;
    logic            FP_reg_write;
    logic [15:0]     tag;
  } exe_p_mux_bus_type;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } fp_rm_e;

  localparam logic [31:0] FP_CANON_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] FP_MAX_FINITE = 32'h7F7F_FFFF;
  localparam logic [31:0] FP_POS_INF    = 32'h7F80_0000;

  typedef struct packed {
    logic              valid;
    logic              sign;
    logic [7:0]        expo;
    logic [22:0]       frac;
    logic              incr;
    logic [2:0]        rm;
    logic              nan;
    logic              inf;
    logic              zero;
`ifdef FPU_FFLAGS_EN
    logic              nv;
    logic              nx;
    logic              tiny;
`endif
    exe_p_mux_bus_type pipe;
  } fp_s1_t;

  // Overflow saturates to infinity or max-finite depending on the rounding direction.
  function automatic logic [31:0] fp_ovf_result(input logic sign, input logic [2:0] rm);
    logic [31:0] r;
    case (fp_rm_e'(rm))
      RM_RTZ:  r = {sign, FP_MAX_FINITE[30:0]};
      RM_RDN:  r = sign ? {1'b1, FP_POS_INF[30:0]} : {1'b0, FP_MAX_FINITE[30:0]};
      RM_RUP:  r = sign ? {1'b1, FP_MAX_FINITE[30:0]} : {1'b0, FP_POS_INF[30:0]};
      default: r = {sign, FP_POS_INF[30:0]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fp_round_incr.sv
// Rounding-increment decision from sign, LSB, guard, round and sticky bits.
module fp_round_incr
  import riscv_types::*;
(
  input  logic       sign_i,
  input  logic       lsb_i,
  input  logic       g_i,
  input  logic       r_i,
  input  logic       s_i,
  input  logic [2:0] rm_i,
  output logic       incr_o,
  output logic       inexact_o
);

  always_comb begin
    inexact_o = g_i | r_i | s_i;
    case (fp_rm_e'(rm_i))
      RM_RTZ:  incr_o = 1'b0;
      RM_RDN:  incr_o = sign_i & (g_i | r_i | s_i);
      RM_RUP:  incr_o = ~sign_i & (g_i | r_i | s_i);
      RM_RMM:  incr_o = g_i;
      default: incr_o = g_i & (r_i | s_i | lsb_i);
    endcase
  end

endmodule

// File: rtl/fpmul_round_pack.sv
// Two-stage round-and-pack for FP multiply results.
// Define FPU_FFLAGS_EN to generate fflags_o; otherwise it is tied to 0.
module fpmul_round_pack
  import riscv_types::*;
#(
  parameter int unsigned addr_width = 5,
  parameter int unsigned num_rds    = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic [num_rds-1:0]                  clear,
  input  logic                                P_signal,
  output logic                                P_O_signal,
  input  logic                                sign_i,
  input  logic [7:0]                          exp_i,
  input  logic [46:0]                         mant_i,
  input  logic                                is_NaN_i,
  input  logic                                is_inf_i,
  input  logic                                is_zero_i,
  input  logic                                nv_i,
  input  logic [2:0]                          rm,
  input  exe_p_mux_bus_type                   pipe_signals_i,
  output exe_p_mux_bus_type                   pipe_signals_o,
  output logic [31:0]                         result_o,
  output logic [4:0]                          fflags_o,
  output logic [num_rds-1:0][addr_width-1:0]  uu_rd,
  output logic [num_rds-1:0]                  uu_reg_write,
  output logic [num_rds-1:0]                  uu_FP_reg_write
);

  fp_s1_t s1_d, s1_q;
  logic   incr, inexact;

  fp_round_incr u_round_incr (
    .sign_i    (sign_i),
    .lsb_i     (mant_i[24]),
    .g_i       (mant_i[23]),
    .r_i       (mant_i[22]),
    .s_i       (|mant_i[21:0]),
    .rm_i      (rm),
    .incr_o    (incr),
    .inexact_o (inexact)
  );

`ifndef FPU_FFLAGS_EN
  logic inexact_unused;
  assign inexact_unused = inexact;
`endif

  always_comb begin
    s1_d = s1_q;
    if (en) begin
      s1_d.valid = P_signal;
      s1_d.sign  = sign_i;
      s1_d.expo  = exp_i;
      s1_d.frac  = mant_i[46:24];
      s1_d.incr  = incr;
      s1_d.rm    = rm;
      s1_d.nan   = is_NaN_i;
      s1_d.inf   = is_inf_i;
      s1_d.zero  = is_zero_i;
`ifdef FPU_FFLAGS_EN
      s1_d.nv    = nv_i;
      s1_d.nx    = inexact;
      s1_d.tiny  = (exp_i == 8'h00);
`endif
      s1_d.pipe  = pipe_signals_i;
    end
    if (clear[1]) s1_d = '0;
  end

  // {exp,frac} is monotone as an integer, so one add handles both fraction carry and subnormal promotion.
  logic [30:0]       sum;
  logic              ovf;
  logic              valid_d, valid_q;
  logic [31:0]       result_d, result_q;
  exe_p_mux_bus_type pipe2_d, pipe2_q;

  always_comb begin
    sum      = {s1_q.expo, s1_q.frac} + {30'b0, s1_q.incr};
    ovf      = (s1_q.expo == 8'hFF) || (sum[30:23] == 8'hFF);
    valid_d  = valid_q;
    result_d = result_q;
    pipe2_d  = pipe2_q;
    if (en) begin
      valid_d = s1_q.valid;
      pipe2_d = s1_q.pipe;
      if (s1_q.nan)       result_d = FP_CANON_NAN;
      else if (s1_q.inf)  result_d = {s1_q.sign, FP_POS_INF[30:0]};
      else if (s1_q.zero) result_d = {s1_q.sign, 31'b0};
      else if (ovf)       result_d = fp_ovf_result(s1_q.sign, s1_q.rm);
      else                result_d = {s1_q.sign, sum};
    end
    if (clear[0]) begin
      valid_d  = 1'b0;
      result_d = '0;
      pipe2_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      pipe2_q  <= '0;
    end else begin
      s1_q     <= s1_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      pipe2_q  <= pipe2_d;
    end
  end

`ifdef FPU_FFLAGS_EN
  logic [4:0] fflags_d, fflags_q;

  always_comb begin
    fflags_d = fflags_q;
    if (en) begin
      if (!s1_q.valid)                 fflags_d = '0;
      else if (s1_q.nan)               fflags_d = {s1_q.nv, 4'b0000};
      else if (s1_q.inf || s1_q.zero)  fflags_d = '0;
      else if (ovf)                    fflags_d = 5'b00101;
      else                             fflags_d = {3'b000, s1_q.nx & s1_q.tiny, s1_q.nx};
    end
    if (clear[0]) fflags_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fflags_q <= '0;
    else        fflags_q <= fflags_d;
  end

  assign fflags_o = fflags_q;
`else
  assign fflags_o = '0;
`endif

  assign P_O_signal         = valid_q;
  assign result_o           = result_q;
  assign pipe_signals_o     = pipe2_q;
  assign uu_rd[1]           = addr_width'(s1_q.pipe.rd);
  assign uu_rd[0]           = addr_width'(pipe2_q.rd);
  assign uu_reg_write[1]    = s1_q.pipe.reg_write;
  assign uu_reg_write[0]    = pipe2_q.reg_write;
  assign uu_FP_reg_write[1] = s1_q.pipe.FP_reg_write;
  assign uu_FP_reg_write[0] = pipe2_q.FP_reg_write;

endmodule

// File: tb/tb_fpmul_round_pack.sv
// Randomized and directed self-checking bench for fpmul_round_pack.
module tb_fpmul_round_pack;
  import riscv_types::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic [1:0]            clear;
  logic                  P_signal, P_O_signal;
  logic                  sign_i;
  logic [7:0]            exp_i;
  logic [46:0]           mant_i;
  logic                  is_NaN_i, is_inf_i, is_zero_i, nv_i;
  logic [2:0]            rm;
  exe_p_mux_bus_type     pipe_signals_i, pipe_signals_o;
  logic [31:0]           result_o;
  logic [4:0]            fflags_o;
  logic [1:0][4:0]       uu_rd;
  logic [1:0]            uu_reg_write, uu_FP_reg_write;

  fpmul_round_pack #(.addr_width(5), .num_rds(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .P_signal(P_signal), .P_O_signal(P_O_signal),
    .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i),
    .is_NaN_i(is_NaN_i), .is_inf_i(is_inf_i), .is_zero_i(is_zero_i), .nv_i(nv_i),
    .rm(rm), .pipe_signals_i(pipe_signals_i), .pipe_signals_o(pipe_signals_o),
    .result_o(result_o), .fflags_o(fflags_o),
    .uu_rd(uu_rd), .uu_reg_write(uu_reg_write), .uu_FP_reg_write(uu_FP_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              v;
    logic [31:0]       res;
    logic [4:0]        fl;
    exe_p_mux_bus_type pipe;
  } mstage_t;

  mstage_t m1, m2;
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h at t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference: round from the tail's relation to one half ulp, then saturate on overflow.
  function automatic mstage_t ref_model();
    mstage_t     r;
    logic [22:0] frac;
    int unsigned tail, up, mag;
    logic        inexact, to_inf;
    frac    = mant_i[46:24];
    tail    = {30'b0, mant_i[23], (mant_i[22] | (|mant_i[21:0]))};
    inexact = (tail != 0);
    case (rm)
      3'd1:    up = 0;
      3'd2:    up = (sign_i && inexact) ? 1 : 0;
      3'd3:    up = (!sign_i && inexact) ? 1 : 0;
      3'd4:    up = (tail >= 2) ? 1 : 0;
      default: up = (tail > 2 || (tail == 2 && frac[0])) ? 1 : 0;
    endcase
    mag    = {1'b0, exp_i, frac} + up;
    r.v    = P_signal;
    r.pipe = pipe_signals_i;
    if (is_NaN_i) begin
      r.res = 32'h7FC00000; r.fl = {nv_i, 4'b0};
    end else if (is_inf_i) begin
      r.res = {sign_i, 31'h7F800000}; r.fl = '0;
    end else if (is_zero_i) begin
      r.res = {sign_i, 31'b0}; r.fl = '0;
    end else if (exp_i == 8'hFF || mag >= 32'h7F800000) begin
      to_inf = (rm == 3'd0) || (rm >= 3'd4) || (rm == 3'd3 && !sign_i) || (rm == 3'd2 && sign_i);
      r.res  = to_inf ? {sign_i, 31'h7F800000} : {sign_i, 31'h7F7FFFFF};
      r.fl   = 5'b00101;
    end else begin
      r.res = {sign_i, mag[30:0]};
      r.fl  = {3'b000, inexact && (exp_i == 8'h00), inexact};
    end
    if (!P_signal) r.fl = '0;
`ifndef FPU_FFLAGS_EN
    r.fl = '0;
`endif
    return r;
  endfunction

  task automatic tick();
    mstage_t cur;
    cur = ref_model();
    @(posedge clk);
    if (clear[0]) m2 = '0; else if (en) m2 = m1;
    if (clear[1]) m1 = '0; else if (en) m1 = cur;
    #1;
    chk("valid", 32'(P_O_signal), 32'(m2.v));
    if (m2.v) chk("result", result_o, m2.res);
    chk("fflags", 32'(fflags_o), 32'(m2.fl));
    chk("pipe_o", 32'(pipe_signals_o), 32'(m2.pipe));
    chk("uu_rd1", 32'(uu_rd[1]), 32'(m1.pipe.rd));
    chk("uu_rd0", 32'(uu_rd[0]), 32'(m2.pipe.rd));
    chk("uu_rw", 32'(uu_reg_write), 32'({m1.pipe.reg_write, m2.pipe.reg_write}));
    chk("uu_fprw", 32'(uu_FP_reg_write), 32'({m1.pipe.FP_reg_write, m2.pipe.FP_reg_write}));
  endtask

  function automatic logic [4:0] fl(input logic [4:0] f);
`ifdef FPU_FFLAGS_EN
    return f;
`else
    return f & 5'b00000;
`endif
  endfunction

  task automatic rand_pipe();
    logic [31:0] rnd;
    rnd = $urandom;
    pipe_signals_i = rnd[$bits(exe_p_mux_bus_type)-1:0];
  endtask

  task automatic set_in(input logic s, input logic [7:0] e, input logic [46:0] m,
                        input logic [2:0] r, input logic [3:0] sp);
    sign_i = s; exp_i = e; mant_i = m; rm = r;
    {is_NaN_i, is_inf_i, is_zero_i, nv_i} = sp;
    P_signal = 1'b1; en = 1'b1; clear = 2'b00;
    rand_pipe();
  endtask

  task automatic directed(input string tag, input logic s, input logic [7:0] e, input logic [46:0] m,
                          input logic [2:0] r, input logic [3:0] sp,
                          input logic [31:0] want_res, input logic [4:0] want_fl);
    set_in(s, e, m, r, sp);
    tick();
    P_signal = 1'b0;
    tick();
    chk({tag, "_res"}, result_o, want_res);
    chk({tag, "_fl"}, 32'(fflags_o), 32'(fl(want_fl)));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_res"}, result_o, 32'h0);
    chk({tag, "_misc"}, 32'({P_O_signal, fflags_o, uu_rd, uu_reg_write, uu_FP_reg_write}), 32'h0);
    chk({tag, "_pipe"}, 32'(pipe_signals_o), 32'h0);
  endtask

  localparam logic [46:0] G_ONLY   = {23'h000000, 1'b1, 23'h0};
  localparam logic [46:0] ONES_G   = {23'h7FFFFF, 1'b1, 23'h0};

  initial begin
    logic [31:0] r32;
    rst_n = 1'b0; en = 1'b0; clear = 2'b00; P_signal = 1'b0;
    sign_i = 1'b0; exp_i = '0; mant_i = '0; rm = '0;
    is_NaN_i = 1'b0; is_inf_i = 1'b0; is_zero_i = 1'b0; nv_i = 1'b0;
    pipe_signals_i = '0;
    m1 = '0; m2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    directed("rne_tie_even", 1'b0, 8'h7F, G_ONLY, 3'd0, 4'b0000, 32'h3F800000, 5'b00001);
    directed("rne_carry",    1'b0, 8'h7F, ONES_G, 3'd0, 4'b0000, 32'h40000000, 5'b00001);
    directed("rtz_nocarry",  1'b0, 8'h7F, ONES_G, 3'd1, 4'b0000, 32'h3FFFFFFF, 5'b00001);
    directed("ovf_rne",      1'b0, 8'hFE, ONES_G, 3'd0, 4'b0000, 32'h7F800000, 5'b00101);
    directed("ovf_rtz",      1'b0, 8'hFE, ONES_G, 3'd1, 4'b0000, 32'h7F7FFFFF, 5'b00101);
    directed("ovf_rup_neg",  1'b1, 8'hFE, ONES_G, 3'd3, 4'b0000, 32'hFF7FFFFF, 5'b00101);
    directed("subn_up",      1'b0, 8'h00, ONES_G, 3'd0, 4'b0000, 32'h00800000, 5'b00011);
    directed("nan_nv",       1'b0, 8'h12, ONES_G, 3'd0, 4'b1001, 32'h7FC00000, 5'b10000);
    directed("inf_neg",      1'b1, 8'h12, ONES_G, 3'd0, 4'b0100, 32'hFF800000, 5'b00000);
    directed("zero_neg",     1'b1, 8'h12, ONES_G, 3'd3, 4'b0010, 32'h80000000, 5'b00000);
    directed("rm_hi_rne",    1'b0, 8'h7F, ONES_G, 3'd6, 4'b0000, 32'h40000000, 5'b00001);

    // Back-to-back with a stall, then a flush of a valid stage 2.
    set_in(1'b0, 8'h80, {23'h1, 24'h0}, 3'd0, 4'b0000); tick();
    set_in(1'b0, 8'h80, {23'h2, 24'h0}, 3'd0, 4'b0000); en = 1'b0; tick();
    en = 1'b1; tick();
    chk("b2b_a", result_o, 32'h40000001);
    set_in(1'b0, 8'h80, {23'h3, 24'h0}, 3'd0, 4'b0000); tick();
    chk("b2b_b", result_o, 32'h40000002);
    set_in(1'b0, 8'h80, {23'h4, 24'h0}, 3'd0, 4'b0000);
    pipe_signals_i.reg_write = 1'b1; tick();
    chk("b2b_c", result_o, 32'h40000003);
    P_signal = 1'b0; tick();
    chk("pre_clear_rw0", 32'(uu_reg_write[0]), 32'h1);
    clear = 2'b01; tick();
    chk("clear_valid", 32'(P_O_signal), 32'h0);
    chk("clear_rw0", 32'(uu_reg_write[0]), 32'h0);
    clear = 2'b00;

    for (int unsigned i = 0; i < 600; i++) begin
      r32 = $urandom;
      sign_i = r32[0];
      case ($urandom_range(0, 5))
        0: exp_i = 8'h00;
        1: exp_i = 8'hFE;
        2: exp_i = 8'hFF;
        default: exp_i = 8'($urandom);
      endcase
      mant_i = {15'($urandom), 32'($urandom)};
      if (r32[1]) mant_i[46:24] = 23'h7FFFFF;
      if (r32[2]) mant_i[21:0] = '0;
      rm = 3'($urandom_range(0, 7));
      is_NaN_i  = ($urandom_range(0, 15) == 0);
      is_inf_i  = ($urandom_range(0, 15) == 0);
      is_zero_i = ($urandom_range(0, 15) == 0);
      nv_i      = r32[3];
      P_signal  = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 4) != 0);
      clear     = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      rand_pipe();
      tick();
    end

    // Asynchronous reset with both stages valid.
    clear = 2'b00;
    set_in(1'b0, 8'h90, {23'h5, 24'h0}, 3'd0, 4'b0000); tick();
    set_in(1'b1, 8'h91, {23'h6, 24'h0}, 3'd0, 4'b0000); tick();
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    m1 = '0; m2 = '0;
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    P_signal = 1'b0; tick();
    tick();
    chk("no_stale", 32'(P_O_signal), 32'h0);
    set_in(1'b0, 8'h81, {23'h7, 24'h0}, 3'd0, 4'b0000); tick();
    chk("post_rst_lat1", 32'(P_O_signal), 32'h0);
    P_signal = 1'b0; tick();
    chk("post_rst_res", result_o, 32'h40800007);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
